// File: rtl/video_pkg.sv
// Shared video definitions: RGB width, scanline mode encodings and the
// beat structure carried through the scanline pipeline.
package video_pkg;

  localparam int RGB_W = 24;

  localparam logic [1:0] SL_OFF = 2'd0;
  localparam logic [1:0] SL_75  = 2'd1;
  localparam logic [1:0] SL_50  = 2'd2;
  localparam logic [1:0] SL_25  = 2'd3;

  typedef struct packed {
    logic [RGB_W-1:0] rgb;
    logic             de;
    logic             hs;
    logic             vs;
  } vid_beat_t;

endpackage

// File: rtl/scanline_dim.sv
// Per-channel scanline intensity reduction, purely combinational.
module scanline_dim
  import video_pkg::*;
(
  input  logic [7:0] c_in,
  input  logic [1:0] mode,
  output logic [7:0] c_out
);

  // c - c/4 never underflows, so plain 8-bit unsigned math is exact
  always_comb begin
    c_out = c_in;
    unique case (mode)
      SL_75:   c_out = c_in - (c_in >> 2);
      SL_50:   c_out = c_in >> 1;
      SL_25:   c_out = c_in >> 2;
      default: c_out = c_in;
    endcase
  end

endmodule

// File: rtl/video_scanlines.sv
// Two-stage scanline darkener: stage 1 registers the pixel and the darken
// decision, stage 2 registers the dimmed/blanked pixel and delayed syncs.
module video_scanlines
  import video_pkg::*;
#(
  parameter logic DARK_ODD = 1'b1
) (
  input  logic             clk_video,
  input  logic             reset_n,
  input  logic [1:0]       scanlines,
  input  logic [RGB_W-1:0] din,
  input  logic             de_in,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic [RGB_W-1:0] dout,
  output logic             de_out,
  output logic             hs_out,
  output logic             vs_out
);

  logic       vs_prev;
  logic       de_prev;
  logic [1:0] act_mode;
  logic       parity;

  logic       vs_rise;
  logic       de_fall;
  logic       dark_now;

  vid_beat_t  s1_beat;
  logic       s1_dark;
  logic [1:0] s1_mode;

  logic [RGB_W-1:0] dimmed;

  assign vs_rise  = vs_in & ~vs_prev;
  assign de_fall  = ~de_in & de_prev;
  // Uses the parity before this cycle's update, so a line's last pixel is
  // never affected by the toggle its own de fall causes.
  assign dark_now = (act_mode != SL_OFF) && (parity == DARK_ODD);

  always_ff @(posedge clk_video) begin
    if (!reset_n) begin
      vs_prev  <= 1'b0;
      de_prev  <= 1'b0;
      act_mode <= SL_OFF;
      parity   <= 1'b0;
    end else begin
      vs_prev <= vs_in;
      de_prev <= de_in;
      if (vs_rise) begin
        act_mode <= scanlines;
      end
      // Frame start wins over a coincident end of line.
      if (vs_rise) begin
        parity <= 1'b0;
      end else if (de_fall) begin
        parity <= ~parity;
      end
    end
  end

  always_ff @(posedge clk_video) begin
    if (!reset_n) begin
      s1_beat <= '0;
      s1_dark <= 1'b0;
      s1_mode <= SL_OFF;
    end else begin
      s1_beat.rgb <= din;
      s1_beat.de  <= de_in;
      s1_beat.hs  <= hs_in;
      s1_beat.vs  <= vs_in;
      s1_dark     <= dark_now;
      s1_mode     <= act_mode;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    scanline_dim u_dim (
      .c_in  (s1_beat.rgb[ch*8 +: 8]),
      .mode  (s1_mode),
      .c_out (dimmed[ch*8 +: 8])
    );
  end

  always_ff @(posedge clk_video) begin
    if (!reset_n) begin
      dout   <= '0;
      de_out <= 1'b0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
    end else begin
      de_out <= s1_beat.de;
      hs_out <= s1_beat.hs;
      vs_out <= s1_beat.vs;
      if (!s1_beat.de) begin
        dout <= '0;
      end else if (s1_dark) begin
        dout <= dimmed;
      end else begin
        dout <= s1_beat.rgb;
      end
    end
  end

endmodule

// File: tb/tb_video_scanlines.sv
// Directed bench for video_scanlines: each driven beat carries its
// hand-computed output, checked two clocks later.
module tb_video_scanlines;

  logic        clk_video = 1'b0;
  logic        reset_n;
  logic [1:0]  scanlines;
  logic [23:0] din;
  logic        de_in, hs_in, vs_in;
  logic [23:0] dout;
  logic        de_out, hs_out, vs_out;

  int tests = 0;
  int fails = 0;
  string cur_tag = "init";
  logic [26:0] exp_q[$];

  always #5 clk_video = ~clk_video;

  video_scanlines #(.DARK_ODD(1'b1)) dut (
    .clk_video (clk_video),
    .reset_n   (reset_n),
    .scanlines (scanlines),
    .din       (din),
    .de_in     (de_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .dout      (dout),
    .de_out    (de_out),
    .hs_out    (hs_out),
    .vs_out    (vs_out)
  );

  task automatic chk(input logic [23:0] e_d, input logic e_de, input logic e_hs, input logic e_vs);
    tests++;
    assert (dout === e_d) else begin
      fails++;
      $error("FAIL %s dout: got %h expected %h", cur_tag, dout, e_d);
    end
    tests++;
    assert (de_out === e_de) else begin
      fails++;
      $error("FAIL %s de_out: got %b expected %b", cur_tag, de_out, e_de);
    end
    tests++;
    assert (hs_out === e_hs) else begin
      fails++;
      $error("FAIL %s hs_out: got %b expected %b", cur_tag, hs_out, e_hs);
    end
    tests++;
    assert (vs_out === e_vs) else begin
      fails++;
      $error("FAIL %s vs_out: got %b expected %b", cur_tag, vs_out, e_vs);
    end
  endtask

  // Drive one beat; the output seen after this edge belongs to the previous beat.
  task automatic px(input logic [23:0] d, input logic de, input logic hs, input logic vs,
                    input logic [23:0] e);
    logic [26:0] x;
    din   = d;
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    exp_q.push_back({e, de, hs, vs});
    @(posedge clk_video);
    #1;
    if (exp_q.size() > 1) begin
      x = exp_q.pop_front();
      chk(x[26:3], x[2], x[1], x[0]);
    end
  endtask

  task automatic line(input logic [23:0] d, input logic [23:0] e, input int n);
    repeat (n) px(d, 1'b1, 1'b0, 1'b0, e);
    px(24'h123456, 1'b0, 1'b1, 1'b0, 24'h000000);
    px(24'h123456, 1'b0, 1'b0, 1'b0, 24'h000000);
  endtask

  task automatic vsync();
    px(24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000);
    px(24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000);
    px(24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000);
  endtask

  initial begin
    // Reset held with a bright active pixel and syncs high: everything must stay 0.
    cur_tag   = "reset";
    reset_n   = 1'b0;
    scanlines = 2'd2;
    din       = 24'hFFFFFF;
    de_in     = 1'b1;
    hs_in     = 1'b1;
    vs_in     = 1'b1;
    repeat (3) begin
      @(posedge clk_video);
      #1;
      chk(24'h000000, 1'b0, 1'b0, 1'b0);
    end
    exp_q.delete();
    reset_n = 1'b1;

    // Mid-frame release: mode stays off until a vsync rise.
    cur_tag = "post_reset";
    line(24'hFFFFFF, 24'hFFFFFF, 3);
    line(24'hFFFFFF, 24'hFFFFFF, 3);

    // Mode 2 (50 %): odd lines halved per channel.
    cur_tag = "mode2";
    scanlines = 2'd2;
    vsync();
    line(24'hFF8040, 24'hFF8040, 4);
    line(24'hFF8040, 24'h7F4020, 4);
    line(24'hFF8040, 24'hFF8040, 4);
    line(24'hFF8040, 24'h7F4020, 4);

    // Mode 1 (75 %): FF - 3F = C0, 03 - 00 = 03.
    cur_tag = "mode1";
    scanlines = 2'd1;
    vsync();
    line(24'hFF0003, 24'hFF0003, 2);
    line(24'hFF0003, 24'hC00003, 2);

    // Mode 3 (25 %): FF>>2 = 3F, 03>>2 = 00.
    cur_tag = "mode3";
    scanlines = 2'd3;
    vsync();
    line(24'hFF0003, 24'hFF0003, 2);
    line(24'hFF0003, 24'h3F0000, 2);

    // Off, then request mode 3 at line 5: no effect until next frame.
    cur_tag = "midframe";
    scanlines = 2'd0;
    vsync();
    for (int ln = 0; ln < 7; ln++) begin
      if (ln == 5) scanlines = 2'd3;
      line(24'hA0B0C0, 24'hA0B0C0, 2);
    end
    cur_tag = "next_frame";
    vsync();
    line(24'hA0B0C0, 24'hA0B0C0, 2);
    line(24'hA0B0C0, 24'h282C30, 2);

    // vsync rise in the same cycle as line 0's de fall: parity must clear, not toggle.
    cur_tag = "vs_de_coincide";
    vsync();
    px(24'hA0B0C0, 1'b1, 1'b0, 1'b0, 24'hA0B0C0);
    px(24'hA0B0C0, 1'b1, 1'b0, 1'b0, 24'hA0B0C0);
    px(24'h123456, 1'b0, 1'b0, 1'b1, 24'h000000);
    px(24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000);
    px(24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000);
    line(24'hA0B0C0, 24'hA0B0C0, 2);
    line(24'hA0B0C0, 24'h282C30, 2);

    // Drain the last beat still in flight.
    cur_tag = "drain";
    px(24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000);
    px(24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
